// File: rtl/kogge_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake on both sides.
// Define KOGGE_OVF_EN to build the signed-overflow output; otherwise Ovf is tied to 0.
module kogge_pipe #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PIPELINE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);
    localparam int unsigned LEVELS = $clog2(WIDTH);

    // One prefix level of span d; returns {G, P}.
    function automatic logic [2*WIDTH-1:0] prefix_lvl(input logic [WIDTH-1:0] g,
                                                       input logic [WIDTH-1:0] p,
                                                       input int unsigned d);
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] po;
        go = g;
        po = p;
        for (int unsigned i = d; i < WIDTH; i++) begin
            go[i] = g[i] | (p[i] & g[i-d]);
            po[i] = p[i] & p[i-d];
        end
        return {go, po};
    endfunction

    logic             w_en;
    logic             r_ov;
    logic             r_v0, r_c0;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_pv, r_c;
    logic [WIDTH-1:0] r_p, r_g;
    logic [WIDTH-1:0] w_gf, w_pf;
    logic             w_cf, w_vf;

    assign w_en     = !(r_ov && !out_ready);
    assign in_ready = w_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_a  <= '0;
            r_b  <= '0;
            r_c0 <= 1'b0;
            r_pv <= 1'b0;
            r_p  <= '0;
            r_g  <= '0;
            r_c  <= 1'b0;
        end else if (w_en) begin
            r_v0 <= in_valid;
            r_a  <= A;
            r_b  <= B ^ {WIDTH{Sub}};
            r_c0 <= Sub | Cin;
            r_pv <= r_v0;
            r_p  <= r_a ^ r_b;
            // Carry-in folded into bit-0 generate so the prefix tree sees it.
            r_g  <= (r_a & r_b) | {{(WIDTH-1){1'b0}}, (r_a[0] ^ r_b[0]) & r_c0};
            r_c  <= r_c0;
        end
    end

    if (PIPELINE != 0) begin : g_pipe
        logic [WIDTH-1:0] r_lg  [LEVELS];
        logic [WIDTH-1:0] r_lp  [LEVELS];
        logic [WIDTH-1:0] r_lp0 [LEVELS];
        logic             r_lc  [LEVELS];
        logic             r_lv  [LEVELS];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned k = 0; k < LEVELS; k++) begin
                    r_lg[k]  <= '0;
                    r_lp[k]  <= '0;
                    r_lp0[k] <= '0;
                    r_lc[k]  <= 1'b0;
                    r_lv[k]  <= 1'b0;
                end
            end else if (w_en) begin
                {r_lg[0], r_lp[0]} <= prefix_lvl(r_g, r_p, 32'd1);
                r_lp0[0] <= r_p;
                r_lc[0]  <= r_c;
                r_lv[0]  <= r_pv;
                for (int unsigned k = 1; k < LEVELS; k++) begin
                    {r_lg[k], r_lp[k]} <= prefix_lvl(r_lg[k-1], r_lp[k-1], 32'd1 << k);
                    r_lp0[k] <= r_lp0[k-1];
                    r_lc[k]  <= r_lc[k-1];
                    r_lv[k]  <= r_lv[k-1];
                end
            end
        end

        assign w_gf = r_lg[LEVELS-1];
        assign w_pf = r_lp0[LEVELS-1];
        assign w_cf = r_lc[LEVELS-1];
        assign w_vf = r_lv[LEVELS-1];
    end else begin : g_flat
        logic [WIDTH-1:0] w_gt, w_pt;

        always_comb begin
            w_gt = r_g;
            w_pt = r_p;
            for (int unsigned k = 0; k < LEVELS; k++) begin
                {w_gt, w_pt} = prefix_lvl(w_gt, w_pt, 32'd1 << k);
            end
        end

        assign w_gf = w_gt;
        assign w_pf = r_p;
        assign w_cf = r_c;
        assign w_vf = r_pv;
    end

    logic [WIDTH-1:0] r_s;
    logic             r_co;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov <= 1'b0;
            r_s  <= '0;
            r_co <= 1'b0;
        end else if (w_en) begin
            r_ov <= w_vf;
            r_s  <= w_pf ^ {w_gf[WIDTH-2:0], w_cf};
            r_co <= w_gf[WIDTH-1];
        end
    end

`ifdef KOGGE_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_gf[WIDTH-2] ^ w_gf[WIDTH-1];
        end
    end

    assign Ovf = r_ovf;
`else
    assign Ovf = 1'b0;
`endif

    assign out_valid = r_ov;
    assign S         = r_s;
    assign Cout      = r_co;

endmodule

// File: tb/tb_kogge_pipe.sv
// Directed bench for kogge_pipe: 16-bit pipelined instance plus a 5-bit PIPELINE=0 instance.
module tb_kogge_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, s;
    logic        in_valid5, in_ready5, cin5, sub5, out_valid5, out_ready5, cout5, ovf5;
    logic [4:0]  a5, b5, s5;

    always #5 clk = ~clk;

    kogge_pipe #(.WIDTH(16), .PIPELINE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
        .Cin(cin), .Sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(s),
        .Cout(cout), .Ovf(ovf)
    );

    kogge_pipe #(.WIDTH(5), .PIPELINE(0)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .A(a5), .B(b5),
        .Cin(cin5), .Sub(sub5), .out_valid(out_valid5), .out_ready(out_ready5), .S(s5),
        .Cout(cout5), .Ovf(ovf5)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co, ov;
    } res_t;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic exp_ovf(input logic v);
`ifdef KOGGE_OVF_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: returns {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [17:0] ref_add(input logic [15:0] aa, input logic [15:0] bb,
                                            input logic ci, input logic su, input int w);
        logic [31:0] m, x, y, sm;
        logic        co, ov;
        m  = (32'd1 << w) - 32'd1;
        x  = {16'd0, aa} & m;
        y  = su ? (~{16'd0, bb}) & m : {16'd0, bb} & m;
        sm = x + y + ((su | ci) ? 32'd1 : 32'd0);
        co = sm[w];
        ov = (x[w-1] == y[w-1]) && (sm[w-1] != x[w-1]);
        return {ov, co, sm[15:0] & m[15:0]};
    endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] aa,
                         input logic [15:0] bb, input logic ci, input logic su);
        if (sel == 0) begin
            in_valid = v; a = aa; b = bb; cin = ci; sub = su;
        end else begin
            in_valid5 = v; a5 = aa[4:0]; b5 = bb[4:0]; cin5 = ci; sub5 = su;
        end
    endtask

    function automatic logic get_irdy(input int sel);
        return (sel == 0) ? in_ready : in_ready5;
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel == 0) ? out_valid : out_valid5;
    endfunction

    function automatic logic [15:0] get_s(input int sel);
        return (sel == 0) ? s : {11'd0, s5};
    endfunction

    function automatic logic get_co(input int sel);
        return (sel == 0) ? cout : cout5;
    endfunction

    task automatic set_ordy(input int sel, input logic r);
        if (sel == 0) out_ready = r;
        else out_ready5 = r;
    endtask

    // Fill the pipe under a stall, hold, then drain and compare in order.
    task automatic stall_test(input int sel, input int w, input string tag);
        res_t        q[$];
        res_t        e;
        int          sent = 0;
        int          got  = 0;
        logic [15:0] aa, bb;
        logic [17:0] r;
        logic        ci, su;
        set_ordy(sel, 1'b0);
        for (int c = 0; c < 15; c++) begin
            if (get_irdy(sel)) begin
                aa = 16'(sent * 37 + 3);
                bb = 16'(sent * 11 + 1);
                ci = sent[0];
                su = (sent % 3 == 1);
                drive(sel, 1'b1, aa, bb, ci, su);
                r = ref_add(aa, bb, ci, su, w);
                q.push_back('{r[15:0], r[16], r[17]});
                sent++;
            end else begin
                drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            end
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check({tag, "_in_ready_low"}, 32'(get_irdy(sel)), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(get_ov(sel)), 32'd1);
            check({tag, "_hold_s"}, 32'(get_s(sel)), 32'(q[0].s));
        end
        set_ordy(sel, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (get_ov(sel)) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check({tag, "_drain_s"}, 32'(get_s(sel)), 32'(e.s));
                    check({tag, "_drain_cout"}, 32'(get_co(sel)), 32'(e.co));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        check({tag, "_drain_count"}, 32'(got), 32'(sent));
    endtask

    initial begin
        res_t        q[$];
        res_t        e;
        logic [15:0] aa, bb;
        logic [17:0] r;
        logic        ci;
        int          lat, sent, got, first, last, stale;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        out_ready  = 1'b1;
        out_ready5 = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_s", 32'(s), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_out_valid5", 32'(out_valid5), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            @(posedge clk); #1;
            drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(exp_ovf(vecs[i].ov)));
            @(posedge clk); #1;
        end

        // Back-to-back stream, out_ready held high.
        sent = 0; got = 0; first = -1; last = -1;
        for (int c = 0; c < 50; c++) begin
            if (out_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("stream_s", 32'(s), 32'(e.s));
                    check("stream_cout", 32'(cout), 32'(e.co));
                    check("stream_ovf", 32'(ovf), 32'(exp_ovf(e.ov)));
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            if (sent < 20) begin
                aa = 16'($urandom);
                bb = 16'($urandom);
                ci = 1'($urandom_range(0, 1));
                drive(0, 1'b1, aa, bb, ci, 1'b0);
                r = ref_add(aa, bb, ci, 1'b0, 16);
                q.push_back('{r[15:0], r[16], r[17]});
                sent++;
            end else begin
                drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            end
            @(posedge clk); #1;
        end
        check("stream_count", 32'(got), 32'd20);
        check("stream_span", 32'(last - first), 32'd19);

        stall_test(0, 16, "stall16");
        stall_test(1, 5, "stall5");

        // Reset while stalled with a full pipe.
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(0, in_ready, 16'(c), 16'(c + 1), 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #3 rst = 1'b1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_s", 32'(s), 32'd0);
        check("midreset_cout", 32'(cout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid || out_valid5) stale++;
        end
        check("post_reset_no_stale", 32'(stale), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
